button_conditioner: RTL and testbench

- Input-side counterpart of the display path: conditions raw front-panel pushbuttons into clean single-cycle command pulses for the timer/clock set logic.
- Pulses drive secplus, minplus, timeset toggling and timereset.
- Per button: 2-flop synchronizer, ms-tick debounce FSM, edge pulses, optional hold-to-auto-repeat.
- Sits between board pins and timer logic in the clk (100 MHz) domain.

---
 rtl/button_pkg.sv | 30 +++
 rtl/btn_channel.sv | 156 +++++++++++++++
 rtl/button_conditioner.sv | 62 ++++++
 tb/tb_button_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types, timing defaults and width helper for the pushbutton conditioner.
// The repeat-timing defaults exist only when BTN_AUTOREPEAT_EN is defined.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } btn_state_t;

    localparam int unsigned DEF_N_BTN       = 4;
    localparam int unsigned DEF_CLK_HZ      = 100_000_000;
    localparam int unsigned DEF_DEBOUNCE_MS = 10;
`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned DEF_REPEAT_DELAY_MS = 500;
    localparam int unsigned DEF_REPEAT_RATE_MS  = 100;
`endif

    // Bits needed to hold n distinct values (0..n-1), never less than 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton: 2-flop synchronizer, ms-tick debounce FSM and pulse outputs.
// BTN_AUTOREPEAT_EN adds hold-to-repeat pulses on cmd_pulse.
module btn_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
`ifdef BTN_AUTOREPEAT_EN
    , parameter int unsigned REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS
    , parameter int unsigned REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
`endif
) (
    input  logic clk,
    input  logic reset_st,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic cmd_pulse
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_MS + 1);

    btn_state_t      state, state_n;
    logic [DB_W-1:0] db_cnt, db_cnt_n;
    logic            sync_a, sync_b;
    logic            db_done;
    logic            level_n, press_n, release_n, cmd_n;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                      REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int unsigned RPT_W   = cnt_width(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_n, rpt_target;
    logic             rpt_armed, rpt_armed_n;
    logic             rpt_fire;

    // First repeat waits the long delay, later ones the short rate.
    assign rpt_target = rpt_armed ? RPT_W'(REPEAT_RATE_MS) : RPT_W'(REPEAT_DELAY_MS);
    assign rpt_fire   = (rpt_cnt + RPT_W'(1)) == rpt_target;
`endif

    assign db_done = (db_cnt + DB_W'(1)) == DB_W'(DEBOUNCE_MS);

    always_ff @(posedge clk or posedge reset_st) begin
        if (reset_st) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk or posedge reset_st) begin
        if (reset_st) begin
            state         <= IDLE;
            db_cnt        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            cmd_pulse     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt       <= '0;
            rpt_armed     <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            db_cnt        <= db_cnt_n;
            level         <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            cmd_pulse     <= cmd_n;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt       <= rpt_cnt_n;
            rpt_armed     <= rpt_armed_n;
`endif
        end
    end

    // Ticks are judged against the synced level seen this cycle, so a level
    // change that coincides with a tick wins over the count.
    always_comb begin
        state_n   = state;
        db_cnt_n  = db_cnt;
        level_n   = level;
        press_n   = 1'b0;
        release_n = 1'b0;
        cmd_n     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_cnt_n   = rpt_cnt;
        rpt_armed_n = rpt_armed;
`endif
        case (state)
            IDLE: begin
                if (sync_b) begin
                    state_n  = DB_PRESS;
                    db_cnt_n = '0;
                end
            end
            DB_PRESS: begin
                if (!sync_b) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (db_done) begin
                        state_n  = HELD;
                        db_cnt_n = DB_W'(DEBOUNCE_MS);
                        level_n  = 1'b1;
                        press_n  = 1'b1;
                        cmd_n    = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_cnt_n   = '0;
                        rpt_armed_n = 1'b0;
`endif
                    end else begin
                        db_cnt_n = db_cnt + DB_W'(1);
                    end
                end
            end
            HELD: begin
                if (!sync_b) begin
                    state_n  = DB_RELEASE;
                    db_cnt_n = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (tick) begin
                    if (rpt_fire) begin
                        cmd_n       = 1'b1;
                        rpt_cnt_n   = '0;
                        rpt_armed_n = 1'b1;
                    end else begin
                        rpt_cnt_n = rpt_cnt + RPT_W'(1);
                    end
                end
`endif
            end
            DB_RELEASE: begin
                if (sync_b) begin
                    state_n = HELD;
                end else if (tick) begin
                    if (db_done) begin
                        state_n   = IDLE;
                        db_cnt_n  = DB_W'(DEBOUNCE_MS);
                        level_n   = 1'b0;
                        release_n = 1'b1;
                    end else begin
                        db_cnt_n = db_cnt + DB_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel pushbutton conditioner: shared 1 ms prescaler plus one debounce
// channel per button. BTN_AUTOREPEAT_EN enables hold-to-repeat on btn_cmd.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned N_BTN       = DEF_N_BTN,
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
`ifdef BTN_AUTOREPEAT_EN
    , parameter int unsigned REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS
    , parameter int unsigned REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
`endif
) (
    input  logic             clk,
    input  logic             reset_st,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_cmd,
    output logic             tick_1ms
);

    localparam int unsigned PERIOD = CLK_HZ / 1000;
    localparam int unsigned PS_W   = cnt_width(PERIOD);

    logic [PS_W-1:0] ps_cnt;

    // Millisecond prescaler; tick_1ms strobes as the count wraps.
    always_ff @(posedge clk or posedge reset_st) begin
        if (reset_st) begin
            ps_cnt   <= '0;
            tick_1ms <= 1'b0;
        end else if (ps_cnt == PS_W'(PERIOD - 1)) begin
            ps_cnt   <= '0;
            tick_1ms <= 1'b1;
        end else begin
            ps_cnt   <= ps_cnt + PS_W'(1);
            tick_1ms <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_MS     (DEBOUNCE_MS)
`ifdef BTN_AUTOREPEAT_EN
            , .REPEAT_DELAY_MS (REPEAT_DELAY_MS)
            , .REPEAT_RATE_MS  (REPEAT_RATE_MS)
`endif
        ) u_ch (
            .clk           (clk),
            .reset_st      (reset_st),
            .raw           (btn_raw[i]),
            .tick          (tick_1ms),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .cmd_pulse     (btn_cmd[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 10-cycle millisecond (P=10).
// Expectations switch on BTN_AUTOREPEAT_EN for the repeat scenario.
module tb_button_conditioner;

    localparam int N = 4;

    logic         clk;
    logic         reset_st;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_cmd;
    logic         tick_1ms;

    button_conditioner #(
        .N_BTN       (N),
        .CLK_HZ      (10_000),
        .DEBOUNCE_MS (3)
`ifdef BTN_AUTOREPEAT_EN
        , .REPEAT_DELAY_MS (20)
        , .REPEAT_RATE_MS  (5)
`endif
    ) dut (
        .clk         (clk),
        .reset_st    (reset_st),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_cmd     (btn_cmd),
        .tick_1ms    (tick_1ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;
    int n_press[N];
    int n_rel[N];
    int n_cmd[N];
    int lvl_hi[N];
    int first_press[N];
    int last_rel[N];
    int cmd_cyc[N][16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0;
        for (int c = 0; c < N; c++) begin
            n_press[c]     = 0;
            n_rel[c]       = 0;
            n_cmd[c]       = 0;
            lvl_hi[c]      = 0;
            first_press[c] = -1;
            last_rel[c]    = -1;
        end
    endtask

    // Advance n cycles, sampling 1 ns after each rising edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < N; c++) begin
                if (btn_press[c]) begin
                    if (n_press[c] == 0) first_press[c] = cyc;
                    n_press[c]++;
                end
                if (btn_release[c]) begin
                    last_rel[c] = cyc;
                    n_rel[c]++;
                end
                if (btn_cmd[c]) begin
                    if (n_cmd[c] < 16) cmd_cyc[c][n_cmd[c]] = cyc;
                    n_cmd[c]++;
                end
                if (btn_level[c]) lvl_hi[c]++;
            end
        end
    endtask

    initial begin
        // Reset with all buttons held; nothing may come out during reset.
        reset_st = 1'b1;
        btn_raw  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({btn_level, btn_press, btn_release, btn_cmd, tick_1ms}), 32'd0);

        // First tick exactly 10 cycles after release; no press before 23 cycles.
        reset_st = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            check("tick_phase", 32'(tick_1ms), 32'((c % 10) == 0));
            check("rst_quiet", 32'({btn_level, btn_press, btn_release, btn_cmd}), 32'd0);
        end
        reset_st = 1'b1;
        btn_raw  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        reset_st = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Clean press on button 0.
        clear_stats();
        btn_raw[0] = 1'b1;
        run(100);
        check("clean_press_cnt", 32'(n_press[0]), 32'd1);
        check("clean_cmd_cnt", 32'(n_cmd[0]), 32'd1);
        check("clean_latency", 32'(first_press[0] >= 23 && first_press[0] <= 33), 32'd1);
        check("clean_cmd_with_press", 32'(cmd_cyc[0][0]), 32'(first_press[0]));
        check("clean_level", 32'(btn_level), 32'h1);
        check("clean_others", 32'(n_press[1] + n_press[2] + n_press[3]), 32'd0);

        // Short bounces on button 1 never get accepted.
        clear_stats();
        for (int r = 0; r < 4; r++) begin
            btn_raw[1] = 1'b1;
            run(15);
            btn_raw[1] = 1'b0;
            run(5);
        end
        run(30);
        check("bounce_no_press", 32'(n_press[1]), 32'd0);
        check("bounce_no_level", 32'(lvl_hi[1]), 32'd0);
        btn_raw[1] = 1'b1;
        run(50);
        check("bounce_then_press", 32'(n_press[1]), 32'd1);
        check("bounce_level", 32'(btn_level), 32'h3);
        check("bounce_ch0_steady", 32'(n_press[0] + n_rel[0]), 32'd0);

        // Bouncy release on button 0.
        clear_stats();
        for (int r = 0; r < 2; r++) begin
            btn_raw[0] = 1'b0;
            run(8);
            btn_raw[0] = 1'b1;
            run(4);
        end
        check("rel_bounce_none", 32'(n_rel[0] + n_press[0]), 32'd0);
        clear_stats();
        btn_raw[0] = 1'b0;
        run(60);
        check("rel_cnt", 32'(n_rel[0]), 32'd1);
        check("rel_latency", 32'(last_rel[0] >= 23 && last_rel[0] <= 33), 32'd1);
        check("rel_no_press", 32'(n_press[0]), 32'd0);
        check("rel_level", 32'(btn_level), 32'h2);

        // Long hold on button 2.
        clear_stats();
        btn_raw[2] = 1'b1;
        run(400);
        btn_raw[2] = 1'b0;
        run(60);
        check("hold_press_cnt", 32'(n_press[2]), 32'd1);
        check("hold_rel_cnt", 32'(n_rel[2]), 32'd1);
        check("hold_first_cmd", 32'(cmd_cyc[2][0]), 32'(first_press[2]));
`ifdef BTN_AUTOREPEAT_EN
        check("rpt_cmd_cnt", 32'(n_cmd[2]), 32'd5);
        check("rpt_delay", 32'(cmd_cyc[2][1] - cmd_cyc[2][0]), 32'd200);
        check("rpt_rate1", 32'(cmd_cyc[2][2] - cmd_cyc[2][1]), 32'd50);
        check("rpt_rate2", 32'(cmd_cyc[2][3] - cmd_cyc[2][2]), 32'd50);
        check("rpt_rate3", 32'(cmd_cyc[2][4] - cmd_cyc[2][3]), 32'd50);
`else
        check("norpt_cmd_cnt", 32'(n_cmd[2]), 32'd1);
`endif

        // Simultaneous presses on buttons 0 and 3 (button 1 lets go here too).
        clear_stats();
        btn_raw = 4'b1001;
        run(50);
        check("simul_press0", 32'(n_press[0]), 32'd1);
        check("simul_press3", 32'(n_press[3]), 32'd1);
        check("simul_same_cycle", 32'(first_press[3]), 32'(first_press[0]));
        check("simul_level", 32'(btn_level), 32'h9);

        // Reset while button 1 is mid-debounce clears everything at once.
        clear_stats();
        btn_raw = 4'b1011;
        run(12);
        check("pre_rst_level", 32'(btn_level), 32'h9);
        #2;
        reset_st = 1'b1;
        #1;
        check("async_rst_clear", 32'({btn_level, btn_press, btn_release, btn_cmd, tick_1ms}), 32'd0);
        btn_raw = 4'h0;
        run(3);
        reset_st = 1'b0;
        run(50);
        check("rst_no_press", 32'(n_press[0] + n_press[1] + n_press[2] + n_press[3]), 32'd0);
        check("rst_no_release", 32'(n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3]), 32'd0);
        check("rst_final_level", 32'(btn_level), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
